seg_scan_decoder: RTL and testbench

//  Receive end of the multiplexed 8-digit seven-segment bus: watches anode select + cathode lines
//  and rebuilds the 8 hex digits being shown. Drives on-chip self-check/readback of the display path.

---
 rtl/seg_scan_decoder.sv | 219 +++++++++++++++++++++
 tb/tb_seg_scan_decoder.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_decoder
// Brief    : Rebuilds the eight hex digits shown on a multiplexed 7-segment
//            bus by watching anode select and cathode lines.
// Revision : 1.0 - initial release
// ============================================================================
module seg_scan_decoder #(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  seg_n,
    input  logic        dp_n,
    input  logic [7:0]  an,
    output logic [31:0] digits,
    output logic [7:0]  digit_valid,
    output logic [7:0]  dp_seen,
    output logic        upd,
    output logic [2:0]  upd_idx,
    output logic        seg_err,
    output logic        an_err,
    output logic        frame_done
);

    localparam int c_stab_w = $clog2(STABLE_CYCLES + 1);
    localparam int c_age_w  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_age_w-1:0] c_age_max = c_age_w'(TIMEOUT_CYCLES);

    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_settle  = 2'd1;
    localparam logic [1:0] c_st_capture = 2'd2;
    localparam logic [1:0] c_st_hold    = 2'd3;

    logic [7:0]          r_s_an;
    logic [6:0]          r_s_seg;
    logic                r_s_dp;
    logic [7:0]          r_ref_an;
    logic [6:0]          r_ref_seg;
    logic                r_ref_dp;
    logic [1:0]          r_state;
    logic [c_stab_w-1:0] r_stab_cnt;
    logic [7:0]          r_mask;

    logic       w_onehot;
    logic       w_multi;
    logic       w_match;
    logic       w_start;
    logic       w_stab_done;
    logic       w_enter_cap;
    logic [2:0] w_idx;
    logic [3:0] w_nib;
    logic       w_code_ok;
    logic [7:0] w_mask_next;
    logic       w_wr_en;
    logic       w_inv_en;

    // Returns {decodable, nibble} for an active-low cathode pattern.
    function automatic logic [4:0] hex_decode(input logic [6:0] code);
        logic [4:0] res;
        case (code)
            7'h01:   res = {1'b1, 4'h0};
            7'h4F:   res = {1'b1, 4'h1};
            7'h12:   res = {1'b1, 4'h2};
            7'h06:   res = {1'b1, 4'h3};
            7'h4C:   res = {1'b1, 4'h4};
            7'h24:   res = {1'b1, 4'h5};
            7'h20:   res = {1'b1, 4'h6};
            7'h0F:   res = {1'b1, 4'h7};
            7'h00:   res = {1'b1, 4'h8};
            7'h04:   res = {1'b1, 4'h9};
            7'h08:   res = {1'b1, 4'hA};
            7'h60:   res = {1'b1, 4'hB};
            7'h31:   res = {1'b1, 4'hC};
            7'h42:   res = {1'b1, 4'hD};
            7'h30:   res = {1'b1, 4'hE};
            7'h38:   res = {1'b1, 4'hF};
            default: res = 5'd0;
        endcase
        return res;
    endfunction

    assign w_onehot = (r_s_an != 8'd0) && ((r_s_an & (r_s_an - 8'd1)) == 8'd0);
    assign w_multi  = (r_s_an != 8'd0) && !w_onehot;
    assign w_match  = ({r_s_an, r_s_seg, r_s_dp} == {r_ref_an, r_ref_seg, r_ref_dp});
    assign {w_code_ok, w_nib} = hex_decode(r_s_seg);

    // On every path into CAPTURE the live sample equals the reference,
    // so the write side decodes the sample directly.
    always_comb begin
        w_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (r_s_an[i]) w_idx = 3'(i);
        end
    end

    always_comb begin
        w_start     = 1'b0;
        w_stab_done = 1'b0;
        case (r_state)
            c_st_idle:   w_start = w_onehot;
            c_st_settle: begin
                if (w_match) w_stab_done = (int'(r_stab_cnt) + 1 >= STABLE_CYCLES);
                else         w_start     = w_onehot;
            end
            c_st_hold:   w_start = !w_match && w_onehot;
            default:     w_start = 1'b0;
        endcase
        w_enter_cap = w_stab_done || (w_start && (STABLE_CYCLES == 1));
    end

    assign w_wr_en     = w_enter_cap && w_code_ok;
    assign w_inv_en    = w_enter_cap && !w_code_ok;
    assign w_mask_next = r_mask | (8'd1 << w_idx);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s_an     <= 8'd0;
            r_s_seg    <= 7'd0;
            r_s_dp     <= 1'b0;
            r_ref_an   <= 8'd0;
            r_ref_seg  <= 7'd0;
            r_ref_dp   <= 1'b0;
            r_state    <= c_st_idle;
            r_stab_cnt <= '0;
            r_mask     <= 8'd0;
            upd        <= 1'b0;
            upd_idx    <= 3'd0;
            seg_err    <= 1'b0;
            an_err     <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            r_s_an     <= an;
            r_s_seg    <= seg_n;
            r_s_dp     <= dp_n;
            upd        <= 1'b0;
            seg_err    <= 1'b0;
            frame_done <= 1'b0;
            if (w_multi) an_err <= 1'b1;

            if (w_start || w_enter_cap) begin
                r_ref_an  <= r_s_an;
                r_ref_seg <= r_s_seg;
                r_ref_dp  <= r_s_dp;
            end

            if (w_enter_cap) begin
                r_state    <= c_st_capture;
                r_stab_cnt <= w_start ? c_stab_w'(1) : r_stab_cnt + c_stab_w'(1);
                upd_idx    <= w_idx;
                if (w_code_ok) begin
                    upd <= 1'b1;
                    if (w_mask_next == 8'hFF) begin
                        frame_done <= 1'b1;
                        r_mask     <= 8'd0;
                    end else begin
                        r_mask <= w_mask_next;
                    end
                end else begin
                    seg_err <= 1'b1;
                end
            end else if (w_start) begin
                r_state    <= c_st_settle;
                r_stab_cnt <= c_stab_w'(1);
            end else begin
                case (r_state)
                    c_st_idle:    r_state <= c_st_idle;
                    c_st_settle: begin
                        if (w_match) r_stab_cnt <= r_stab_cnt + c_stab_w'(1);
                        else         r_state    <= c_st_idle;
                    end
                    c_st_capture: r_state <= c_st_hold;
                    c_st_hold: begin
                        if (!w_match) r_state <= c_st_idle;
                    end
                    default:      r_state <= c_st_idle;
                endcase
            end
        end
    end

    for (genvar gi = 0; gi < 8; gi++) begin : g_digit
        logic [3:0]         r_nib;
        logic               r_valid;
        logic               r_dp;
        logic [c_age_w-1:0] r_age;
        logic               w_sel;

        assign w_sel = (w_idx == 3'(gi));

        // A capture of this digit takes priority over its own timeout.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_nib   <= 4'd0;
                r_valid <= 1'b0;
                r_dp    <= 1'b0;
                r_age   <= '0;
            end else if (w_wr_en && w_sel) begin
                r_nib   <= w_nib;
                r_dp    <= ~r_s_dp;
                r_valid <= 1'b1;
                r_age   <= '0;
            end else begin
                if (r_age < c_age_max) begin
                    r_age <= r_age + 1'b1;
                    if (r_age + 1'b1 == c_age_max) r_valid <= 1'b0;
                end
                if (w_inv_en && w_sel) r_valid <= 1'b0;
            end
        end

        assign digits[4*gi +: 4] = r_nib;
        assign digit_valid[gi]   = r_valid;
        assign dp_seen[gi]       = r_dp;
    end

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_scan_decoder
// Brief    : Directed and randomized bench for seg_scan_decoder against a
//            run-length reference model of the display bus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_scan_decoder;

    localparam int S = 4;
    localparam int T = 80;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic [6:0]  seg_n = 7'h7F;
    logic        dp_n  = 1'b1;
    logic [7:0]  an    = 8'd0;
    logic [31:0] digits;
    logic [7:0]  digit_valid;
    logic [7:0]  dp_seen;
    logic        upd;
    logic [2:0]  upd_idx;
    logic        seg_err;
    logic        an_err;
    logic        frame_done;

    seg_scan_decoder #(.STABLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst), .seg_n(seg_n), .dp_n(dp_n), .an(an),
        .digits(digits), .digit_valid(digit_valid), .dp_seen(dp_seen),
        .upd(upd), .upd_idx(upd_idx), .seg_err(seg_err), .an_err(an_err),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [6:0] hex_tab [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                                 7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

    // Reference model: value-level view of the bus, one update per clock edge.
    logic [3:0]  m_nib [8];
    int          m_age [8];
    logic [7:0]  m_valid, m_dp, m_mask;
    logic        m_upd, m_segerr, m_anerr, m_fd;
    logic [2:0]  m_idx;
    logic [15:0] m_samp, m_ref;
    logic        m_track, m_captured, m_blind;
    int          m_run;

    task automatic model_clear();
        for (int i = 0; i < 8; i++) begin
            m_nib[i] = 4'd0;
            m_age[i] = 0;
        end
        m_valid = 8'd0; m_dp = 8'd0; m_mask = 8'd0;
        m_upd = 1'b0; m_segerr = 1'b0; m_anerr = 1'b0; m_fd = 1'b0;
        m_idx = 3'd0; m_samp = 16'd0; m_ref = 16'd0;
        m_track = 1'b0; m_captured = 1'b0; m_blind = 1'b0; m_run = 0;
    endtask

    task automatic model_edge();
        logic [7:0] a;
        int         idx;
        int         nib;
        bit         cap;
        if (rst) begin
            model_clear();
            return;
        end
        a = m_samp[15:8];
        m_upd = 1'b0; m_segerr = 1'b0; m_fd = 1'b0;
        if ($countones(a) > 1) m_anerr = 1'b1;
        cap = 1'b0;
        if (m_blind) begin
            m_blind = 1'b0;
        end else if (m_track && m_samp == m_ref) begin
            if (!m_captured) begin
                m_run++;
                if (m_run >= S) cap = 1'b1;
            end
        end else if ($countones(a) == 1) begin
            m_track = 1'b1; m_ref = m_samp; m_run = 1; m_captured = 1'b0;
            if (S == 1) cap = 1'b1;
        end else begin
            m_track = 1'b0;
        end
        for (int i = 0; i < 8; i++) begin
            if (m_age[i] < T) begin
                m_age[i]++;
                if (m_age[i] == T) m_valid[i] = 1'b0;
            end
        end
        if (cap) begin
            m_captured = 1'b1;
            m_blind    = 1'b1;
            idx = 0;
            for (int i = 0; i < 8; i++) if (a[i]) idx = i;
            m_idx = 3'(idx);
            nib = -1;
            for (int k = 0; k < 16; k++) if (hex_tab[k] == m_samp[7:1]) nib = k;
            if (nib >= 0) begin
                m_nib[idx] = 4'(nib); m_dp[idx] = ~m_samp[0];
                m_valid[idx] = 1'b1; m_age[idx] = 0; m_upd = 1'b1;
                m_mask[idx] = 1'b1;
                if (m_mask == 8'hFF) begin
                    m_fd = 1'b1; m_mask = 8'd0;
                end
            end else begin
                m_segerr = 1'b1; m_valid[idx] = 1'b0;
            end
        end
        m_samp = {an, seg_n, dp_n};
    endtask

    function automatic logic [31:0] m_pack();
        logic [31:0] v;
        v = 32'd0;
        for (int i = 0; i < 8; i++) v[4*i +: 4] = m_nib[i];
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("digits",      digits,      m_pack());
        chk("digit_valid", {24'd0, digit_valid}, {24'd0, m_valid});
        chk("dp_seen",     {24'd0, dp_seen},     {24'd0, m_dp});
        chk("upd",         {31'd0, upd},         {31'd0, m_upd});
        chk("upd_idx",     {29'd0, upd_idx},     {29'd0, m_idx});
        chk("seg_err",     {31'd0, seg_err},     {31'd0, m_segerr});
        chk("an_err",      {31'd0, an_err},      {31'd0, m_anerr});
        chk("frame_done",  {31'd0, frame_done},  {31'd0, m_fd});
    end

    // Event counters for the directed literal checks.
    int         cyc = 0, upd_cnt = 0, se_cnt = 0, fd_cnt = 0;
    logic [2:0] last_idx = 3'd0, err_idx = 3'd0, fd_idx = 3'd0;
    int         cap5_cyc = -1, fall5_cyc = -1;
    logic       prev_v5 = 1'b0, watch3 = 1'b0, bad3 = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (upd === 1'b1) begin
            upd_cnt++; last_idx = upd_idx;
            if (upd_idx == 3'd5) cap5_cyc = cyc;
        end
        if (seg_err === 1'b1) begin
            se_cnt++; err_idx = upd_idx;
        end
        if (frame_done === 1'b1) begin
            fd_cnt++; fd_idx = upd_idx;
        end
        if (prev_v5 && !digit_valid[5]) fall5_cyc = cyc;
        prev_v5 = digit_valid[5];
        if (watch3 && digits[15:12] != 4'd3) bad3 = 1'b1;
    end

    task automatic step(input logic [7:0] a, input logic [6:0] s, input logic d);
        an = a; seg_n = s; dp_n = d;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        #1;
    endtask

    task automatic hold(input logic [7:0] a, input logic [6:0] s, input logic d, input int n);
        repeat (n) step(a, s, d);
    endtask

    initial begin
        logic [7:0] ra;
        logic [6:0] rs;
        int         p, x, y;
        model_clear();

        rst = 1'b1;
        hold(8'd0, 7'h7F, 1'b1, 2);
        chk("rst_digits", digits, 32'd0);
        chk("rst_valid",  {24'd0, digit_valid}, 32'd0);
        chk("rst_flags",  {28'd0, upd, seg_err, an_err, frame_done}, 32'd0);
        rst = 1'b0;

        // Single digit held steady
        upd_cnt = 0;
        hold(8'h01, 7'h12, 1'b1, 10);
        chk("t1_upd_cnt", upd_cnt, 1);
        chk("t1_idx",     {29'd0, last_idx}, 32'd0);
        chk("t1_digit0",  {28'd0, digits[3:0]}, 32'd2);
        chk("t1_valid",   {24'd0, digit_valid}, 32'h01);
        chk("t1_dp0",     {31'd0, dp_seen[0]}, 32'd0);
        hold(8'h01, 7'h12, 1'b1, 5);
        chk("t1_no_recap", upd_cnt, 1);

        // Full frame scan
        upd_cnt = 0; fd_cnt = 0;
        for (int k = 0; k < 8; k++) hold(8'(1 << k), hex_tab[k], 1'b1, 8);
        chk("t2_upd_cnt", upd_cnt, 8);
        chk("t2_fd_cnt",  fd_cnt, 1);
        chk("t2_fd_idx",  {29'd0, fd_idx}, 32'd7);
        chk("t2_digits",  digits, 32'h76543210);
        chk("t2_valid",   {24'd0, digit_valid}, 32'hFF);

        // Blank pattern is not a hex code
        upd_cnt = 0; se_cnt = 0;
        hold(8'h04, 7'h7F, 1'b1, 8);
        chk("t3_se_cnt",  se_cnt, 1);
        chk("t3_err_idx", {29'd0, err_idx}, 32'd2);
        chk("t3_upd_cnt", upd_cnt, 0);
        chk("t3_valid2",  {31'd0, digit_valid[2]}, 32'd0);

        // Short flip never writes the glitch value
        hold(8'h08, 7'h06, 1'b1, 8);
        upd_cnt = 0; watch3 = 1'b1;
        hold(8'h08, 7'h00, 1'b1, 2);
        hold(8'h08, 7'h06, 1'b1, 8);
        watch3 = 1'b0;
        chk("t4_no_glitch", {31'd0, bad3}, 32'd0);
        chk("t4_digit3",    {28'd0, digits[15:12]}, 32'd3);
        chk("t4_recap_cnt", upd_cnt, 1);
        chk("t4_anerr_pre", {31'd0, an_err}, 32'd0);
        step(8'h03, 7'h06, 1'b1);
        hold(8'h08, 7'h06, 1'b1, 6);
        chk("t4_anerr", {31'd0, an_err}, 32'd1);

        // Timeout after scanning stops
        fall5_cyc = -1;
        hold(8'h20, 7'h24, 1'b1, 8);
        hold(8'h00, 7'h7F, 1'b1, T + 10);
        chk("t5_timeout", fall5_cyc - cap5_cyc, T);
        chk("t5_digit5",  {28'd0, digits[23:20]}, 32'd5);
        chk("t5_valid5",  {31'd0, digit_valid[5]}, 32'd0);

        // Reset during settling
        hold(8'h02, 7'h4F, 1'b1, 3);
        rst = 1'b1;
        step(8'h02, 7'h4F, 1'b1);
        chk("t6_digits", digits, 32'd0);
        chk("t6_vec",    {8'd0, digit_valid, dp_seen, 8'd0}, 32'd0);
        chk("t6_flags",  {25'd0, upd_idx, upd, seg_err, an_err, frame_done}, 32'd0);
        rst = 1'b0;
        upd_cnt = 0;
        hold(8'h02, 7'h4F, 1'b1, 4);
        chk("t6_no_upd", upd_cnt, 0);
        step(8'h02, 7'h4F, 1'b1);
        chk("t6_upd",    upd_cnt, 1);
        chk("t6_digit1", {28'd0, digits[7:4]}, 32'd1);

        // Randomized scanning with glitches, blanks, multi-hot and resets
        for (int r = 0; r < 250; r++) begin
            p = $urandom_range(0, 19);
            x = $urandom_range(0, 7);
            if (p < 15)      ra = 8'(1 << x);
            else if (p < 18) ra = 8'd0;
            else begin
                y  = (x + 1 + $urandom_range(0, 6)) % 8;
                ra = 8'(1 << x) | 8'(1 << y);
            end
            rs = ($urandom_range(0, 9) < 8) ? hex_tab[$urandom_range(0, 15)] : 7'($urandom);
            if ($urandom_range(0, 99) == 0) begin
                rst = 1'b1;
                step(ra, rs, 1'($urandom));
                rst = 1'b0;
            end
            hold(ra, rs, 1'($urandom), $urandom_range(1, 8));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
